// File: rtl/regfile_loader.sv
// Write-side sequencer for the 32x32 FP-adder register file: queues (addr, data)
// commands, writes each one, reads it back and flags the first mismatching address.
module regfile_loader #(
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        err_clr,
    output logic        rf_we,
    output logic        rf_mode,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [4:0]  err_addr,
    output logic [7:0]  wr_count,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] LAST_RD = 2'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]  fifo_addr_q [DEPTH];
    logic [31:0] fifo_data_q [DEPTH];
    logic [1:0]  rd_cnt_q, rd_cnt_d;
    logic        rf_we_q, rf_we_d;
    logic        rf_mode_q, rf_mode_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [4:0]  err_addr_q, err_addr_d;
    logic [7:0]  wr_count_q, wr_count_d;

    logic empty, full, push, pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready = !full && !reset;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && !empty;

    // FIFO storage carries no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q[AW-1:0]] <= cmd_addr;
            fifo_data_q[wr_ptr_q[AW-1:0]] <= cmd_data;
        end
    end

    // rf_addr_q / rf_wdata_q double as the working registers of the command in flight.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        rd_cnt_d   = rd_cnt_q;
        rf_we_d    = 1'b0;
        rf_mode_d  = 1'b1;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        wr_count_d = wr_count_q;

        if (err_clr) begin
            err_d      = 1'b0;
            err_addr_d = 5'd0;
        end

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    rf_addr_d  = fifo_addr_q[rd_ptr_q[AW-1:0]];
                    rf_wdata_d = fifo_data_q[rd_ptr_q[AW-1:0]];
                    rf_we_d    = 1'b1;
                    rf_mode_d  = 1'b0;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                rd_cnt_d = 2'd0;
                state_d  = S_READ;
            end
            S_READ: begin
                if (rd_cnt_q == LAST_RD) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    wr_count_d = wr_count_q + 8'd1;
                    // A mismatch beats a simultaneous clear and re-captures the address.
                    if (rf_rdata != rf_wdata_q) begin
                        err_d = 1'b1;
                        if (!err_q || err_clr) begin
                            err_addr_d = rf_addr_q;
                        end
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_cnt_q   <= 2'd0;
            rf_we_q    <= 1'b0;
            rf_mode_q  <= 1'b1;
            rf_addr_q  <= 5'd0;
            rf_wdata_q <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= 5'd0;
            wr_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_cnt_q   <= rd_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_mode_q  <= rf_mode_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_mode   = rf_mode_q;
    assign rf_addr   = rf_addr_q;
    assign rf_wdata  = rf_wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_addr  = err_addr_q;
    assign wr_count  = wr_count_q;
    assign busy      = (state_q != S_IDLE) || !empty;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_loader.sv
// Directed bench for regfile_loader: one RD_LAT=1 instance with a corruptible RF
// model and write monitor, plus one RD_LAT=3 instance for read-latency timing.
module tb_regfile_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset;
    logic        cmd_valid, cmd_ready, err_clr;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        rf_we, rf_mode, busy, done, err;
    logic [4:0]  rf_addr, err_addr;
    logic [31:0] rf_wdata, rf_rdata;
    logic [7:0]  wr_count;
    logic [1:0]  dbg_state;

    logic        d3_cmd_valid, d3_cmd_ready;
    logic [4:0]  d3_cmd_addr;
    logic [31:0] d3_cmd_data;
    logic        d3_rf_we, d3_rf_mode, d3_busy, d3_done, d3_err;
    logic [4:0]  d3_rf_addr, d3_err_addr;
    logic [31:0] d3_rf_wdata, d3_rf_rdata;
    logic [7:0]  d3_wr_count;
    logic [1:0]  d3_dbg_state;

    regfile_loader #(.DEPTH(4), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .err_clr(err_clr),
        .rf_we(rf_we), .rf_mode(rf_mode), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .busy(busy), .done(done), .err(err), .err_addr(err_addr),
        .wr_count(wr_count), .dbg_state(dbg_state)
    );

    regfile_loader #(.DEPTH(4), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready),
        .cmd_addr(d3_cmd_addr), .cmd_data(d3_cmd_data), .err_clr(1'b0),
        .rf_we(d3_rf_we), .rf_mode(d3_rf_mode), .rf_addr(d3_rf_addr), .rf_wdata(d3_rf_wdata),
        .rf_rdata(d3_rf_rdata), .busy(d3_busy), .done(d3_done), .err(d3_err),
        .err_addr(d3_err_addr), .wr_count(d3_wr_count), .dbg_state(d3_dbg_state)
    );

    // Register file models: latency 1 with optional bit-0 corruption per address; latency 3 pipe.
    logic [31:0] mem1 [32];
    logic [31:0] corrupt_mask;
    always @(posedge clk) begin
        if (rf_we) mem1[rf_addr] <= rf_wdata;
        rf_rdata <= mem1[rf_addr] ^ {31'd0, corrupt_mask[rf_addr]};
    end

    logic [31:0] mem3 [32];
    logic [31:0] p0, p1;
    always @(posedge clk) begin
        if (d3_rf_we) mem3[d3_rf_addr] <= d3_rf_wdata;
        p0 <= mem3[d3_rf_addr];
        p1 <= p0;
        d3_rf_rdata <= p1;
    end

    // Write/done monitor for the RD_LAT=1 instance.
    logic [4:0]  obs_addr [$];
    logic [31:0] obs_data [$];
    int          done_cyc [$];
    always @(posedge clk) begin
        if (rf_we) begin
            obs_addr.push_back(rf_addr);
            obs_data.push_back(rf_wdata);
        end
        if (done) done_cyc.push_back(cyc);
    end

    logic [4:0]  exp_addr_q [$];
    logic [31:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        obs_addr.delete();
        obs_data.delete();
        done_cyc.delete();
        exp_addr_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({rf_we, rf_mode, rf_addr, rf_wdata, done, err, err_addr, wr_count, busy, cmd_ready} !==
            {1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b mode=%b addr=%0d wdata=%h done=%b err=%b eaddr=%0d cnt=%0d busy=%b rdy=%b",
                     rf_we, rf_mode, rf_addr, rf_wdata, done, err, err_addr, wr_count, busy, cmd_ready);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
        tick();
    endtask

    task automatic test_single();
        clear_queues();
        cmd_valid = 1'b1; cmd_addr = 5'd22; cmd_data = 32'h41360001;
        tick();  // E0
        cmd_valid = 1'b0;
        checks++;
        if ({busy, rf_we} !== 2'b10) begin
            errors++;
            $display("FAIL single_e0 busy/we: got %b expected 10", {busy, rf_we});
        end
        tick();  // E1
        checks++;
        if ({rf_we, rf_mode, rf_addr, rf_wdata} !== {1'b1, 1'b0, 5'd22, 32'h41360001}) begin
            errors++;
            $display("FAIL single_write: got we=%b mode=%b addr=%0d wdata=%h expected 1 0 22 41360001",
                     rf_we, rf_mode, rf_addr, rf_wdata);
        end
        tick();  // E2
        checks++;
        if ({rf_we, rf_mode, rf_addr, rf_wdata, done} !== {1'b0, 1'b1, 5'd22, 32'h41360001, 1'b0}) begin
            errors++;
            $display("FAIL single_read: got we=%b mode=%b addr=%0d wdata=%h done=%b expected 0 1 22 41360001 0",
                     rf_we, rf_mode, rf_addr, rf_wdata, done);
        end
        tick();  // E3
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_early: got %b expected 0", done);
        end
        tick();  // E4
        checks++;
        if ({done, wr_count, err, busy, dbg_state} !== {1'b1, 8'd1, 1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL single_done: got done=%b cnt=%0d err=%b busy=%b st=%0d expected 1 1 0 0 0",
                     done, wr_count, err, busy, dbg_state);
        end
        tick();  // E5
        checks++;
        if ({done, 32'(obs_addr.size())} !== {1'b0, 32'd1}) begin
            errors++;
            $display("FAIL single_after: got done=%b we_cycles=%0d expected 0 1", done, obs_addr.size());
        end
        checks++;
        if (mem1[22] !== 32'h41360001) begin
            errors++;
            $display("FAIL single_rf_content: got %h expected 41360001", mem1[22]);
        end
    endtask

    task automatic test_burst();
        int nd;
        logic [4:0]  ba [3];
        logic [31:0] bd [3];
        ba = '{5'd22, 5'd28, 5'd31};
        bd = '{32'h41360001, 32'h40B2041B, 32'h41878107};
        clear_queues();
        for (int i = 0; i < 3; i++) begin
            exp_addr_q.push_back(ba[i]);
            exp_q.push_back(bd[i]);
        end
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_addr = ba[i];
            cmd_data = bd[i];
            tick();
        end
        cmd_valid = 1'b0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) begin
                nd++;
                if (nd == 3) begin
                    tick();
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL burst_busy_fall: got %b expected 0", busy);
                    end
                    break;
                end
            end
        end
        checks++;
        if (nd != 3 || done_cyc.size() != 3) begin
            errors++;
            $display("FAIL burst_done_count: got %0d expected 3", nd);
        end else begin
            checks++;
            if (done_cyc[1] - done_cyc[0] != 4 || done_cyc[2] - done_cyc[1] != 4) begin
                errors++;
                $display("FAIL burst_done_spacing: got %0d,%0d expected 4,4",
                         done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
            end
        end
        checks++;
        if (obs_addr.size() != 3) begin
            errors++;
            $display("FAIL burst_write_count: got %0d expected 3", obs_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_addr[i] !== exp_addr_q[i] || obs_data[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL burst_order[%0d]: got %0d/%h expected %0d/%h",
                             i, obs_addr[i], obs_data[i], exp_addr_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (wr_count !== 8'd4 || err !== 1'b0) begin
            errors++;
            $display("FAIL burst_wr_count: got cnt=%0d err=%b expected 4 0", wr_count, err);
        end
    endtask

    task automatic test_fifo_full();
        int k, first_stall;
        logic was_ready;
        logic [4:0]  fa [6];
        logic [31:0] fd [6];
        fa = '{5'd3, 5'd5, 5'd5, 5'd9, 5'd10, 5'd11};
        fd = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'hC0800000, 32'h7F800000, 32'h00000001};
        clear_queues();
        for (int i = 0; i < 6; i++) begin
            exp_addr_q.push_back(fa[i]);
            exp_q.push_back(fd[i]);
        end
        k = 0;
        first_stall = -1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40 && k < 6; i++) begin
            cmd_addr  = fa[k];
            cmd_data  = fd[k];
            was_ready = cmd_ready;
            if (!was_ready && first_stall < 0) first_stall = k;
            tick();
            if (was_ready) k++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (k != 6) begin
            errors++;
            $display("FAIL fifo_accept_all: got %0d expected 6", k);
        end
        checks++;
        if (first_stall != 5) begin
            errors++;
            $display("FAIL fifo_full_point: got stall after %0d pushes expected 5", first_stall);
        end
        for (int i = 0; i < 60 && done_cyc.size() < 6; i++) tick();
        tick();
        checks++;
        if (done_cyc.size() != 6 || obs_addr.size() != 6) begin
            errors++;
            $display("FAIL fifo_complete: got done=%0d writes=%0d expected 6 6", done_cyc.size(), obs_addr.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs_addr[i] !== exp_addr_q[i] || obs_data[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL fifo_order[%0d]: got %0d/%h expected %0d/%h",
                             i, obs_addr[i], obs_data[i], exp_addr_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (mem1[5] !== 32'h40400000 || wr_count !== 8'd10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fifo_last_wins: got mem5=%h cnt=%0d busy=%b expected 40400000 10 0", mem1[5], wr_count, busy);
        end
    endtask

    task automatic test_error();
        logic [4:0] ea [4];
        logic [4:0] ee [4];
        ea = '{5'd28, 5'd31, 5'd28, 5'd31};
        ee = '{5'd28, 5'd28, 5'd28, 5'd31};
        corrupt_mask = 32'd0;
        corrupt_mask[28] = 1'b1;
        corrupt_mask[31] = 1'b1;
        for (int s = 0; s < 4; s++) begin
            if (s == 2) begin
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                checks++;
                if ({err, err_addr} !== {1'b0, 5'd0}) begin
                    errors++;
                    $display("FAIL err_clear: got err=%b addr=%0d expected 0 0", err, err_addr);
                end
            end
            cmd_valid = 1'b1; cmd_addr = ea[s]; cmd_data = 32'h40B20400 + 32'(s);
            tick();  // E0
            cmd_valid = 1'b0;
            tick();
            tick();
            tick();  // E3
            if (s == 3) err_clr = 1'b1;
            tick();  // E4: compare edge
            err_clr = 1'b0;
            checks++;
            if ({done, err, err_addr} !== {1'b1, 1'b1, ee[s]}) begin
                errors++;
                $display("FAIL err_step%0d: got done=%b err=%b addr=%0d expected 1 1 %0d",
                         s, done, err, err_addr, ee[s]);
            end
            tick();
        end
        checks++;
        if (wr_count !== 8'd14) begin
            errors++;
            $display("FAIL err_wr_count: got %0d expected 14", wr_count);
        end
        corrupt_mask = 32'd0;
    endtask

    task automatic test_reset_mid();
        logic found;
        clear_queues();
        cmd_valid = 1'b1;
        cmd_addr = 5'd1; cmd_data = 32'h11110001; tick();
        cmd_addr = 5'd2; cmd_data = 32'h22220002; tick();
        cmd_addr = 5'd4; cmd_data = 32'h44440004; tick();
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rf_we && rf_addr == 5'd2) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_second_write: got none expected write to addr 2");
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({rf_we, rf_mode, rf_addr, rf_wdata, done, err, err_addr, wr_count, busy, cmd_ready} !==
            {1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_async: got we=%b mode=%b addr=%0d wdata=%h done=%b err=%b cnt=%0d busy=%b rdy=%b",
                     rf_we, rf_mode, rf_addr, rf_wdata, done, err, wr_count, busy, cmd_ready);
        end
        tick();
        tick();
        clear_queues();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (obs_addr.size() != 0 || done_cyc.size() != 0) begin
            errors++;
            $display("FAIL mid_discard: got writes=%0d dones=%0d expected 0 0", obs_addr.size(), done_cyc.size());
        end
        checks++;
        if ({cmd_ready, busy, wr_count} !== {1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL mid_after_release: got rdy=%b busy=%b cnt=%0d expected 1 0 0", cmd_ready, busy, wr_count);
        end
    endtask

    task automatic test_rd_lat3();
        logic [31:0] ld [2];
        ld = '{32'h11111111, 32'h22222222};
        for (int c = 0; c < 2; c++) begin
            d3_cmd_valid = 1'b1; d3_cmd_addr = 5'd7; d3_cmd_data = ld[c];
            tick();  // E0
            d3_cmd_valid = 1'b0;
            for (int e = 1; e <= 6; e++) begin
                tick();
                checks++;
                if ({d3_rf_we, d3_done} !== {1'(e == 1), 1'(e == 6)}) begin
                    errors++;
                    $display("FAIL lat3_cmd%0d_E%0d: got we=%b done=%b expected %b %b",
                             c, e, d3_rf_we, d3_done, 1'(e == 1), 1'(e == 6));
                end
            end
            tick();
        end
        checks++;
        if ({d3_err, d3_wr_count, d3_busy} !== {1'b0, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL lat3_final: got err=%b cnt=%0d busy=%b expected 0 2 0", d3_err, d3_wr_count, d3_busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_addr = 5'd0; cmd_data = 32'd0; err_clr = 1'b0;
        d3_cmd_valid = 1'b0; d3_cmd_addr = 5'd0; d3_cmd_data = 32'd0;
        corrupt_mask = 32'd0;
        test_reset();
        test_single();
        test_burst();
        test_fifo_full();
        test_error();
        test_reset_mid();
        test_rd_lat3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
